// File: rtl/dpb_pkg.sv
// Shared constants, reader state encoding and helpers for the dual-port
// buffer read path.
package dpb_pkg;

   localparam int DPB_ADDR_W      = 11;
   localparam int DPB_DATA_W      = 128;
   localparam int BYTES_PER_WORD  = 16;
   localparam int WORDS_PER_RANK  = 128;
   localparam int MAX_SLICE_BYTES = 2048;

   localparam int RANK_W = 4;
   localparam int WIDX_W = 7;
   localparam int LEN_W  = 12;

   typedef enum logic [2:0] {
      RD_IDLE  = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      RD_EMIT  = 3'd3,
      RD_DONE  = 3'd4
   } rd_state_t;

   // A slice length is usable when it is non-zero and fits one rank.
   function automatic logic len_is_legal(input logic [LEN_W-1:0] len);
      return (len != 12'd0) && (len <= 12'd2048);
   endfunction

endpackage

// File: rtl/dpb_byte_reader_if.sv
// Byte-stream and buffer-port bundle of the byte reader. The master side is
// the reader; the slave side is the buffer plus the byte consumer.
interface dpb_byte_reader_if;
   import dpb_pkg::*;

   logic                  o_byte_de;
   logic [7:0]            o_byte_data;
   logic                  o_byte_last;
   logic                  i_byte_ready;

   logic [DPB_DATA_W-1:0] i_dpb_rd_data;
   logic [DPB_ADDR_W-1:0] o_dpb_addr;
   logic                  o_dpb_clk;
   logic                  o_dpb_cea;
   logic                  o_dpb_ocea;
   logic                  o_dpb_rst_n;
   logic                  o_dpb_wr_en;
   logic [DPB_DATA_W-1:0] o_dpb_wr_data;

   modport master (
      output o_byte_de, o_byte_data, o_byte_last,
      input  i_byte_ready,
      input  i_dpb_rd_data,
      output o_dpb_addr, o_dpb_clk, o_dpb_cea, o_dpb_ocea,
      output o_dpb_rst_n, o_dpb_wr_en, o_dpb_wr_data
   );

   modport slave (
      input  o_byte_de, o_byte_data, o_byte_last,
      output i_byte_ready,
      output i_dpb_rd_data,
      input  o_dpb_addr, o_dpb_clk, o_dpb_cea, o_dpb_ocea,
      input  o_dpb_rst_n, o_dpb_wr_en, o_dpb_wr_data
   );

endinterface

// File: rtl/dpb_word_serializer.sv
// Turns one captured 128-bit buffer word into a ready/valid byte stream.
// Tracks the bytes still owed for the slice so a partial final word stops
// early, and raises the last flag with the final byte of the slice.
module dpb_word_serializer
   import dpb_pkg::*;
#(
   parameter bit BYTE_MSB_FIRST = 1'b1
) (
   input  logic                  i_cam_pclk,
   input  logic                  rst_n,
   input  logic                  len_load,
   input  logic [LEN_W-1:0]      len_val,
   input  logic                  word_load,
   input  logic [DPB_DATA_W-1:0] word_data,
   input  logic                  byte_ready,
   output logic                  byte_de,
   output logic [7:0]            byte_data,
   output logic                  byte_last,
   output logic                  word_done,
   output logic                  slice_done
);

   logic [DPB_DATA_W-1:0] word_r;
   logic [3:0]            idx_r;
   logic [LEN_W-1:0]      rem_r;
   logic                  de_r;
   logic [7:0]            data_r;
   logic                  last_r;

   logic                  hs_s;
   logic                  last_byte_s;
   logic                  word_end_s;

   // Byte idx of a word; ordering chosen by BYTE_MSB_FIRST.
   function automatic logic [7:0] pick_byte(input logic [DPB_DATA_W-1:0] word,
                                            input logic [3:0]            idx);
      logic [DPB_DATA_W-1:0] sh;
      if (BYTE_MSB_FIRST) begin
         sh = word >> {4'd15 - idx, 3'b000};
      end else begin
         sh = word >> {idx, 3'b000};
      end
      return sh[7:0];
   endfunction

   assign hs_s        = de_r & byte_ready;
   assign last_byte_s = (rem_r == 12'd1);
   assign word_end_s  = (idx_r == 4'd15);

   assign word_done   = hs_s & word_end_s & ~last_byte_s;
   assign slice_done  = hs_s & last_byte_s;

   assign byte_de     = de_r;
   assign byte_data   = data_r;
   assign byte_last   = last_r;

   // Word capture, byte stepping on handshakes, hold while stalled.
   always_ff @(posedge i_cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         word_r <= {DPB_DATA_W{1'b0}};
         idx_r  <= 4'd0;
         rem_r  <= 12'd0;
         de_r   <= 1'b0;
         data_r <= 8'd0;
         last_r <= 1'b0;
      end else begin
         if (len_load) begin
            rem_r <= len_val;
         end else if (hs_s) begin
            rem_r <= rem_r - 12'd1;
         end else begin
            rem_r <= rem_r;
         end

         if (word_load) begin
            word_r <= word_data;
            idx_r  <= 4'd0;
            de_r   <= 1'b1;
            data_r <= pick_byte(word_data, 4'd0);
            last_r <= last_byte_s;
         end else if (hs_s) begin
            idx_r <= idx_r + 4'd1;
            if (word_end_s || last_byte_s) begin
               de_r   <= 1'b0;
               last_r <= 1'b0;
            end else begin
               data_r <= pick_byte(word_r, idx_r + 4'd1);
               last_r <= (rem_r == 12'd2);
            end
         end else begin
            de_r <= de_r;
         end
      end
   end

endmodule

// File: rtl/dpb_byte_reader.sv
// Reads one MJPEG slice back out of the 128-bit dual-port buffer through its
// spare port and streams it as bytes. The FSM issues one word read per 16
// bytes, waits out the buffer read latency, then hands the word to the
// serializer. Addresses are {rank, word index} and stay inside the rank.
module dpb_byte_reader
   import dpb_pkg::*;
#(
   parameter int RD_LATENCY     = 2,
   parameter bit BYTE_MSB_FIRST = 1'b1
) (
   input  logic               i_cam_pclk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [RANK_W-1:0]  i_buf_rank,
   input  logic [LEN_W-1:0]   i_byte_len,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error,
   dpb_byte_reader_if.master  bus
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

   rd_state_t             state_r;
   logic [RANK_W-1:0]     rank_r;
   logic [WIDX_W-1:0]     widx_r;
   logic [1:0]            wait_cnt_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  error_r;
   logic                  cea_r;
   logic [DPB_ADDR_W-1:0] addr_r;

   logic                  start_ok_s;
   logic                  word_load_s;
   logic                  word_done_s;
   logic                  slice_done_s;

   assign start_ok_s  = (state_r == RD_IDLE) && i_start && len_is_legal(i_byte_len);
   assign word_load_s = (state_r == RD_WAIT) && (wait_cnt_r == LAT_LAST);

   assign o_busy  = busy_r;
   assign o_done  = done_r;
   assign o_error = error_r;

   assign bus.o_dpb_addr    = addr_r;
   assign bus.o_dpb_cea     = cea_r;
   assign bus.o_dpb_clk     = i_cam_pclk;
   assign bus.o_dpb_rst_n   = rst_n;
   assign bus.o_dpb_ocea    = 1'b1;
   assign bus.o_dpb_wr_en   = 1'b0;
   assign bus.o_dpb_wr_data = {DPB_DATA_W{1'b0}};

   dpb_word_serializer #(
      .BYTE_MSB_FIRST (BYTE_MSB_FIRST)
   ) u_ser (
      .i_cam_pclk (i_cam_pclk),
      .rst_n      (rst_n),
      .len_load   (start_ok_s),
      .len_val    (i_byte_len),
      .word_load  (word_load_s),
      .word_data  (bus.i_dpb_rd_data),
      .byte_ready (bus.i_byte_ready),
      .byte_de    (bus.o_byte_de),
      .byte_data  (bus.o_byte_data),
      .byte_last  (bus.o_byte_last),
      .word_done  (word_done_s),
      .slice_done (slice_done_s)
   );

   // Slice sequencing, address generation and registered status outputs.
   always_ff @(posedge i_cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= RD_IDLE;
         rank_r     <= 4'd0;
         widx_r     <= 7'd0;
         wait_cnt_r <= 2'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         cea_r      <= 1'b0;
         addr_r     <= 11'd0;
      end else begin
         case (state_r)
            RD_IDLE: begin
               done_r <= 1'b0;
               cea_r  <= 1'b0;
               if (start_ok_s) begin
                  rank_r  <= i_buf_rank;
                  widx_r  <= 7'd0;
                  busy_r  <= 1'b1;
                  cea_r   <= 1'b1;
                  addr_r  <= {i_buf_rank, 7'd0};
                  state_r <= RD_ISSUE;
               end else if (i_start) begin
                  error_r <= 1'b1;
               end else begin
                  state_r <= RD_IDLE;
               end
            end
            RD_ISSUE: begin
               cea_r      <= 1'b0;
               wait_cnt_r <= 2'd0;
               state_r    <= RD_WAIT;
            end
            RD_WAIT: begin
               if (wait_cnt_r == LAT_LAST) begin
                  state_r <= RD_EMIT;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 2'd1;
               end
            end
            RD_EMIT: begin
               if (word_done_s) begin
                  widx_r  <= widx_r + 7'd1;
                  addr_r  <= {rank_r, widx_r + 7'd1};
                  cea_r   <= 1'b1;
                  state_r <= RD_ISSUE;
               end else if (slice_done_s) begin
                  done_r  <= 1'b1;
                  state_r <= RD_DONE;
               end else begin
                  state_r <= RD_EMIT;
               end
            end
            RD_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= RD_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               cea_r   <= 1'b0;
               state_r <= RD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dpb_byte_reader.md
Name: dpb_byte_reader

Overview:
- Reads one MJPEG slice back out of a 128-bit dual-port buffer and serializes it into a byte stream.
- It is the read-side counterpart of the MJPEG byte packer that fills the buffer as {buf_rank, 128cnt} words.
- It sits on the buffer's spare port in the i_cam_pclk domain and feeds loopback checking and local consumers with ready/valid backpressure.

Parameters:
RD_LATENCY, 2, cycles from o_dpb_addr/o_dpb_cea to valid i_dpb_rd_data (2 = output register enabled via ocea); legal values 1..3
BYTE_MSB_FIRST, 1, 1: byte 0 of a word is [127:120]; 0: byte 0 is [7:0]

Ports:
i_cam_pclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle request; accepted only when o_busy=0
i_buf_rank  in  4  slot index; sampled on an accepted i_start
i_byte_len  in  12  bytes to read, legal 1..2048; sampled on an accepted i_start
o_busy  out  1  high from accepted start until o_done
o_done  out  1  one-cycle pulse after the last byte handshake
o_byte_de  out  1  byte valid
o_byte_data  out  8  byte value
o_byte_last  out  1  high with the final byte of the slice
i_byte_ready  in  1  consumer ready; a byte transfers when o_byte_de & i_byte_ready
i_dpb_rd_data  in  128  buffer read data
o_dpb_addr  out  11  {rank, word index}
o_dpb_clk  out  1  equals i_cam_pclk
o_dpb_cea  out  1  read clock enable
o_dpb_ocea  out  1  output-register enable, tied 1
o_dpb_rst_n  out  1  equals rst_n
o_dpb_wr_en  out  1  tied 0
o_dpb_wr_data  out  128  tied 0
o_error  out  1  sticky flag, cleared only by reset

Behaviour:
- Reset values:
  - o_busy, o_done, o_byte_de, o_byte_last, o_dpb_cea, o_error = 0.
  - o_byte_data = 0, o_dpb_addr = 0.
  - State = IDLE.
- IDLE:
  - i_start with i_byte_len in 1..2048: latch rank and length, set the word index to 0 and the remaining-byte count to len, raise o_busy next cycle, go to ISSUE.
  - i_start with len 0 or >2048: set o_error, stay in IDLE, o_busy stays 0.
- ISSUE (1 cycle): o_dpb_addr = {rank, widx}, o_dpb_cea = 1, go to WAIT. o_dpb_cea is 0 in every other state.
- WAIT: count RD_LATENCY-1 cycles, then capture i_dpb_rd_data into the shift register and load the byte index with 0. Go to EMIT.
- EMIT:
  - o_byte_de = 1 with the current byte selected per BYTE_MSB_FIRST.
  - On each handshake: decrement remaining and increment the byte index.
  - o_byte_last = (remaining == 1).
  - After the handshake on byte 15 with remaining > 1: widx += 1, go to ISSUE.
  - After the handshake on the final byte: go to DONE.
  - A partial last word emits only the remaining bytes; the trailing bytes are discarded.
- DONE (1 cycle): o_done = 1, o_busy = 0 next cycle, go to IDLE.
- Backpressure: o_byte_data and o_byte_last hold stable while o_byte_de = 1 and i_byte_ready = 0.
- i_start while busy: ignored, no error.
- Widths:
  - widx is 7 bits and never wraps inside one slice; 2048 bytes = 128 words, last widx = 127.
  - rank selects the 128-word region; addresses never cross into the next rank.
- Latency: accepted start at cycle 0 gives first o_byte_de at cycle 2+RD_LATENCY. Each new word costs 1+RD_LATENCY bubble cycles.
- Reset mid-slice: all state and outputs return to reset values immediately; no o_done is emitted.

Decomposition:
- Shared package dpb_pkg holds:
  - DPB_ADDR_W = 11, DPB_DATA_W = 128, BYTES_PER_WORD = 16, WORDS_PER_RANK = 128, MAX_SLICE_BYTES = 2048.
  - The reader state enum {RD_IDLE, RD_ISSUE, RD_WAIT, RD_EMIT, RD_DONE}.
- One sub-module is natural: dpb_word_serializer, a 128-to-8 shift/select with byte index, hold-on-stall and last-flag generation. The FSM and address generation stay in dpb_byte_reader.

Test Plan:
1. Buffer model preloaded: rank 3, word 0 = 0x000102…0F. Start rank=3, len=16, ready=1 → o_dpb_addr=0x180; bytes 00..0F on consecutive cycles starting at cycle 4 (RD_LATENCY=2); last with 0x0F; o_done 1 cycle later.
2. len=20, rank=0, words 0/1 with incrementing bytes → 16 bytes, 3-cycle bubble, addr 0x001, bytes 0x10..0x13; last on 0x13; bytes 0x14..0x1F never presented.
3. len=2048, rank=15, ready toggling every cycle → exactly 2048 transfers; final address 0x7FF; data matches the model; output held stable during every stall; o_error=0.
4. i_start with len=0, then with len=2049 → o_error=1, o_busy stays 0, o_dpb_cea never asserted; a subsequent valid start still completes normally.
5. Assert rst_n low after 7 transferred bytes of a 32-byte slice → outputs at reset values in the same cycle, no o_done; a new start after release begins at word 0.
6. Second i_start pulsed mid-slice with rank=5 → ignored; all addresses stay in the original rank; exactly one o_done.
